// File: rtl/lsu_mem_master.sv
// Byte-addressed RISC-V load/store initiator for a word-addressed data memory (SB/SH via RMW).
// Define LSU_RANGE_CHECK_EN to report word indices >= MEM_DEPTH as errors instead of forwarding.
module lsu_mem_master #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] RD     = 3'd2;
    localparam logic [2:0] WR     = 3'd3;
    localparam logic [2:0] RMW_RD = 3'd4;
    localparam logic [2:0] RMW_WR = 3'd5;
    localparam logic [2:0] RESP   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [1:0]        lane;
    logic              align_err;
    logic              funct3_err;
    logic              range_err;
    logic              req_err;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    assign lane     = addr_q[1:0];
    assign mem_addr = {2'b00, addr_q[ADDR_W-1:2]};

    // Decode of the captured request, consumed only in CHECK.
    always_comb begin
        align_err  = 1'b0;
        funct3_err = 1'b0;
        case (funct3_q)
            3'd0: ;
            3'd1: align_err = lane[0];
            3'd2: align_err = |lane;
            3'd4: funct3_err = write_q;
            3'd5: begin
                funct3_err = write_q;
                align_err  = lane[0];
            end
            default: funct3_err = 1'b1;
        endcase
    end

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = mem_addr >= ADDR_W'(MEM_DEPTH);
`else
    assign range_err = 1'b0;
`endif

    assign req_err = align_err | funct3_err | range_err;

    always_comb begin
        rd_byte = mem_rdata[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'h0, rd_byte};
            3'd5:    load_ext = {16'h0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Only SB (funct3 0) and SH (funct3 1) reach the RMW path.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[0]) begin
            if (lane[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_valid) state_d = CHECK;
            CHECK: begin
                if (req_err) begin
                    state_d = RESP;
                end else if (!write_q) begin
                    state_d = RD;
                end else if (funct3_q == 3'd2) begin
                    state_d = WR;
                end else begin
                    state_d = RMW_RD;
                end
            end
            RD:     state_d = RESP;
            WR:     state_d = RESP;
            RMW_RD: state_d = RMW_WR;
            RMW_WR: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            // Response registers change only on the edge into RESP, so they hold in between.
            case (state_q)
                CHECK: begin
                    if (req_err) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RD: begin
                    rsp_rdata_q <= load_ext;
                    rsp_err_q   <= 1'b0;
                end
                WR, RMW_WR: begin
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                RMW_RD: merge_q <= merged;
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_read  = (state_q == RD) || (state_q == RMW_RD);
    assign mem_write = (state_q == WR) || (state_q == RMW_WR);

    always_comb begin
        mem_wdata = 32'h0;
        if (state_q == WR) begin
            mem_wdata = wdata_q;
        end else if (state_q == RMW_WR) begin
            mem_wdata = merge_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests queue their expected response,
// a negedge monitor pops and compares on every rsp_valid pulse.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic        poke_en = 1'b0;
    logic [6:0]  poke_idx = 7'd0;
    logic [31:0] poke_val = 32'h0;

    int checks = 0;
    int failures = 0;
    int rsp_count = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    lsu_mem_master #(
        .MEM_DEPTH(64),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr[6:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[6:0]] <= mem_wdata;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            logic [32:0] e;
            string       n;
            rsp_count++;
            check("rsp_ready_low", {31'h0, req_ready}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "/rdata"}, rsp_rdata, e[31:0]);
                check({n, "/err"}, {31'h0, rsp_err}, {31'h0, e[32]});
            end
        end
    end

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_idx = idx[6:0];
        poke_val = val;
        poke_en  = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "/req_ready"}, {31'h0, req_ready}, 32'h1);
        check({pfx, "/rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({pfx, "/rsp_err"}, {31'h0, rsp_err}, 32'h0);
        check({pfx, "/rsp_rdata"}, rsp_rdata, 32'h0);
        check({pfx, "/mem_read"}, {31'h0, mem_read}, 32'h0);
        check({pfx, "/mem_write"}, {31'h0, mem_write}, 32'h0);
        check({pfx, "/mem_addr"}, mem_addr, 32'h0);
        check({pfx, "/mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Cycle k = the cycle after the k-th edge, counting the accept edge as edge 1.
    // exp_lat is the first k with rsp_valid; exp_rcyc/exp_wcyc the single k with mem_read/mem_write (0 = none).
    task automatic xact(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_rcyc, input int exp_wcyc, input logic [31:0] exp_wword);
        int         lat;
        int         waited;
        logic [7:0] rmask;
        logic [7:0] wmask;
        logic [7:0] exp_rm;
        logic [7:0] exp_wm;
        exp_q.push_back({exp_err, exp_rd});
        name_q.push_back(name);
        @(negedge clk);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check({name, "/accept_timeout"}, 32'h1, 32'h0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rmask = 8'h0;
        wmask = 8'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid && lat == 0) lat = k;
            if (mem_read) rmask[k] = 1'b1;
            if (mem_write) begin
                wmask[k] = 1'b1;
                check({name, "/mem_wdata"}, mem_wdata, exp_wword);
            end
            if (mem_read || mem_write) check({name, "/mem_addr"}, mem_addr, addr >> 2);
        end
        exp_rm = 8'h0;
        exp_wm = 8'h0;
        if (exp_rcyc > 0) exp_rm[exp_rcyc] = 1'b1;
        if (exp_wcyc > 0) exp_wm[exp_wcyc] = 1'b1;
        check({name, "/latency"}, 32'(lat), 32'(exp_lat));
        check({name, "/read_cycles"}, {24'h0, rmask}, {24'h0, exp_rm});
        check({name, "/write_cycles"}, {24'h0, wmask}, {24'h0, exp_wm});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        int acc_cyc[3];
        int rsp_before;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Word write then byte loads
        xact("sw_10", 1'b1, 3'd2, 32'h10, 32'h8081_7F01, 32'h0, 1'b0, 3, 0, 2, 32'h8081_7F01);
        check("mem4_after_sw", mem[4], 32'h8081_7F01);
        xact("lb_11", 1'b0, 3'd0, 32'h11, 32'h0, 32'h0000_007F, 1'b0, 3, 2, 0, 32'h0);
        xact("lb_13", 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 2, 0, 32'h0);
        xact("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, 2, 0, 32'h0);

        // Reset during RMW_RD of an SB abandons it: no write, no response
        poke(8, 32'h1234_5678);
        @(negedge clk);
        req_write  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_00AA;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_read && waited < 10);
        check("rst_mid/in_rmw_rd", {31'h0, mem_read}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid/no_write", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid/mem8_kept", mem[8], 32'h1234_5678);

        // Halfword and byte read-modify-write
        poke(4, 32'h1122_3344);
        xact("sh_12", 1'b1, 3'd1, 32'h12, 32'hABCD_BEEF, 32'h0, 1'b0, 4, 2, 3, 32'hBEEF_3344);
        xact("lh_12", 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 2, 0, 32'h0);
        xact("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0, 3, 2, 0, 32'h0);
        xact("sb_11", 1'b1, 3'd0, 32'h11, 32'h1234_565A, 32'h0, 1'b0, 4, 2, 3, 32'hBEEF_5A44);
        xact("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hBEEF_5A44, 1'b0, 3, 2, 0, 32'h0);
        xact("lh_10", 1'b0, 3'd1, 32'h10, 32'h0, 32'h0000_5A44, 1'b0, 3, 2, 0, 32'h0);

        // Misaligned and illegal accesses
        xact("lw_mis06", 1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
        xact("sh_mis05", 1'b1, 3'd1, 32'h05, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 0, 0, 32'h0);
        xact("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
        xact("st_f3_4", 1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 0, 0, 32'h0);
        check("mem4_after_errs", mem[4], 32'hBEEF_5A44);

        // Back-to-back loads with req_valid held high
        exp_q.push_back({1'b0, 32'hBEEF_5A44});
        name_q.push_back("b2b_lw_10");
        exp_q.push_back({1'b0, 32'h0000_00EF});
        name_q.push_back("b2b_lbu_12");
        exp_q.push_back({1'b0, 32'hFFFF_FFEF});
        name_q.push_back("b2b_lb_12");
        rsp_before = rsp_count;
        @(negedge clk);
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waited = 0;
            while (!req_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            @(posedge clk);
            #1 acc_cyc[i] = cyc;
            if (i == 0) begin
                req_funct3 = 3'd4;
                req_addr   = 32'h12;
            end else if (i == 1) begin
                req_funct3 = 3'd0;
                req_addr   = 32'h12;
            end else begin
                req_valid = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        check("b2b/spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        check("b2b/spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        check("b2b/rsp_pulses", 32'(rsp_count - rsp_before), 32'd3);

        // Word index 64 is past MEM_DEPTH
        poke(64, 32'hCAFE_F00D);
`ifdef LSU_RANGE_CHECK_EN
        xact("lw_range", 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
`else
        xact("lw_range", 1'b0, 3'd2, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 2, 0, 32'h0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
